lag_ejection_arbiter: RTL
=========================

# LAG_ejection_arbiter

Multiplexes the `global_links_num` ejection links of one router onto a single sink port. Each exit link feeds a per-link flit FIFO. A packet-locked round-robin arbiter drains the FIFOs into one registered `flit_out`, so flits of different packets never interleave. Per-link `cntrl_out` credit pulses are returned to the router as flits leave the FIFOs. The block sits between the router exit links and a single-channel `LAG_traffic_sink` instance.

## Interface
- `global_links_num`, 2: number of ejection links; legal range 1..8.
- `buf_depth`, 4: flits per link FIFO; power of two, 2..16; equals the upstream credit count per link.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; one clock, reset is asynchronous and active-low.
- `flit_in`  input  flit_t [global_links_num-1:0]  ejection flits; a flit is present when `control.valid`=1.
- `cntrl_out`  output  [global_links_num-1:0]  credit return; one-cycle pulse per flit dequeued from link i.
- `flit_out`  output  flit_t  flit to the sink; registered.
- `sink_ready`  input  1  sink accepts a flit this cycle.
- `overflow_err`  output  1  sticky; set when a flit is written to a full FIFO and dropped.
- `occupancy`  output  [global_links_num*5-1:0]  per-link FIFO count; field i is bits [5i+4:5i].

## Operation
- **Enqueue:** at each edge, `flit_in[i]` with `control.valid`=1 is written to FIFO i, the whole flit_t unchanged.
- **Full write with dequeue:** a write to full FIFO i is accepted if FIFO i dequeues on the same edge.
- **Full write without dequeue:** the flit is dropped and `overflow_err` is set. `overflow_err` clears only on reset.
- **Arbiter state UNLOCKED:**
  - Grant goes to the first non-empty FIFO scanning from `rr_ptr` upward, modulo `global_links_num`.
  - If the granted flit has `control.tail`=0, go to LOCKED(owner=k).
  - If it has `control.tail`=1 (single-flit packet), stay UNLOCKED and set `rr_ptr`=k+1 mod N.
- **Arbiter state LOCKED(k):**
  - Only FIFO k is eligible. An empty FIFO k produces a bubble; no other link is served.
  - Dequeuing a tail flit returns the arbiter to UNLOCKED and sets `rr_ptr`=k+1 mod N.
- **Dequeue condition:** a dequeue happens only when `sink_ready`=1 and the eligible FIFO is non-empty.
- **On each dequeue edge:**
  - `flit_out` is loaded with the head flit, `control.valid`=1.
  - `cntrl_out[k]` is set to 1 for that one cycle.
- **No dequeue:** `flit_out.control.valid`=0 and all `cntrl_out` bits are 0. Valid is never held across cycles.
- **Counters:** FIFO pointers are log2(`buf_depth`) bits wide and wrap naturally. The count is log2(`buf_depth`)+1 bits wide, zero-extended to 5 bits.
- **Count update:** `occupancy[i]` = writes minus reads. A simultaneous write and read leaves the count unchanged.

## Timing
- **Reset values:**
  - All FIFOs empty, arbiter UNLOCKED, `rr_ptr`=0.
  - `flit_out`='0, `cntrl_out`=0, `overflow_err`=0, `occupancy`=0.
- **Reset mid-packet:** discards FIFO contents and any lock immediately. No credit is returned for discarded flits.
- **Latency:** a flit valid on `flit_in[i]` in cycle t is stored at the end of t. It is earliest dequeued at the end of t+1 and appears on `flit_out` in cycle t+2.
- **Credit timing:** the `cntrl_out[i]` pulse is coincident with that flit on `flit_out`.
- **Throughput:** one flit per cycle aggregate while `sink_ready`=1 and the eligible FIFO is non-empty.
- **Fairness:** after any tail, a waiting link is granted within N-1 packets.
- **`sink_ready` deassertion:** freezes arbitration state and FIFOs. Enqueues continue.

## Test plan
- **Reset values:** assert `rst_n`=0 asynchronously mid-cycle → all outputs 0 immediately.
- **Reset mid-packet:** drive 3-flit packets on link 0, release reset, assert reset again mid-packet → FIFOs flushed; `occupancy`=0; after release the first grant goes to link 0 from UNLOCKED.
- **Single-link latency:** one 4-flit packet on link 0 (valid cycles 0-3), `sink_ready`=1 → `flit_out` valid cycles 2-5 with flit_id 1..4 in order; `cntrl_out[0]` pulses in cycles 2-5.
- **Packet lock and round robin:** N=2; 3-flit packets on links 0 and 1 both start at cycle 0 → link 0 flits in cycles 2-4, link 1 flits in cycles 5-7, never interleaved; next simultaneous contention is granted to link 0 again (`rr_ptr`=0 after link 1's tail).
- **Bubble under lock:** link 0 sends head at cycle 0 and tail at cycle 5; link 1 is continuously full → `flit_out` idle in cycles 3-6, link 1 not served until after link 0's tail (cycle 7).
- **Backpressure and overflow:** `sink_ready`=0, 4 flits into link 1 (depth 4) → `occupancy[1]`=4, no `cntrl_out`. A 5th flit → dropped and `overflow_err`=1, sticky. `sink_ready`=1 in the same cycle as a 5th write → accepted, `overflow_err` stays 0.

Source files
------------

// File: rtl/lag_ejection_arbiter.sv
// Flit types shared by the ejection arbiter and its users, followed by the arbiter.
// Per-link flit FIFOs drained by a packet-locked round-robin arbiter into one
// registered sink port, with per-link credit return pulses.
package lag_pkg;

   typedef struct packed {
      logic valid;
      logic head;
      logic tail;
   } flit_ctrl_t;

   typedef struct packed {
      flit_ctrl_t  control;
      logic [7:0]  flit_id;
      logic [15:0] data;
   } flit_t;

endpackage

module lag_ejection_arbiter
   import lag_pkg::*;
#(
   parameter int unsigned global_links_num = 2,
   parameter int unsigned buf_depth        = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  flit_t [global_links_num-1:0]    flit_in,
   output logic  [global_links_num-1:0]    cntrl_out,
   output flit_t                           flit_out,
   input  logic                            sink_ready,
   output logic                            overflow_err,
   output logic  [global_links_num*5-1:0]  occupancy
);

   localparam int unsigned AW = (buf_depth > 1) ? $clog2(buf_depth) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned IW = (global_links_num > 1) ? $clog2(global_links_num) : 1;

   // (base + off) mod N, used for the rotating scan and the post-tail pointer.
   function automatic logic [IW-1:0] link_add(input logic [IW-1:0] base, input int unsigned off);
      return IW'((int'(base) + off) % global_links_num);
   endfunction

   flit_t          mem_q    [global_links_num][buf_depth];
   logic [AW-1:0]  wr_ptr_q [global_links_num];
   logic [AW-1:0]  rd_ptr_q [global_links_num];
   logic [CW-1:0]  cnt_q    [global_links_num];

   logic           locked_q, locked_d;
   logic [IW-1:0]  owner_q, owner_d;
   logic [IW-1:0]  rr_q, rr_d;

   logic           found;
   logic           deq;
   logic [IW-1:0]  sel;
   flit_t          head;
   flit_t          flit_out_d;
   logic [global_links_num-1:0] deq_vec;
   logic [global_links_num-1:0] wr_vec;
   logic           ovf_set;

   // Pick the eligible link: the owner while locked, else first non-empty from rr_q.
   always_comb begin
      sel   = owner_q;
      found = 1'b0;
      if (locked_q) begin
         found = (cnt_q[owner_q] != '0);
      end else begin
         for (int unsigned off = 0; off < global_links_num; off++) begin
            if (!found && cnt_q[link_add(rr_q, off)] != '0) begin
               found = 1'b1;
               sel   = link_add(rr_q, off);
            end
         end
      end
      deq  = sink_ready && found;
      head = mem_q[sel][rd_ptr_q[sel]];
   end

   // Per-link dequeue/enqueue strobes; a full FIFO only takes a write when it also drains.
   always_comb begin
      deq_vec = '0;
      wr_vec  = '0;
      ovf_set = 1'b0;
      for (int unsigned i = 0; i < global_links_num; i++) begin
         deq_vec[i] = deq && (sel == IW'(i));
         wr_vec[i]  = flit_in[i].control.valid &&
                      ((cnt_q[i] != CW'(buf_depth)) || deq_vec[i]);
         if (flit_in[i].control.valid && (cnt_q[i] == CW'(buf_depth)) && !deq_vec[i]) begin
            ovf_set = 1'b1;
         end
      end
   end

   // Lock/round-robin next state and the registered output flit.
   always_comb begin
      locked_d   = locked_q;
      owner_d    = owner_q;
      rr_d       = rr_q;
      flit_out_d = '0;
      if (deq) begin
         flit_out_d               = head;
         flit_out_d.control.valid = 1'b1;
         if (head.control.tail) begin
            locked_d = 1'b0;
            rr_d     = link_add(sel, 1);
         end else begin
            locked_d = 1'b1;
            owner_d  = sel;
         end
      end
   end

   // FIFO storage; contents need no reset since counts gate every read.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < global_links_num; i++) begin
         if (wr_vec[i]) begin
            mem_q[i][wr_ptr_q[i]] <= flit_in[i];
         end
      end
   end

   // FIFO pointers and counts; reset flushes every link without returning credits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < global_links_num; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < global_links_num; i++) begin
            if (wr_vec[i]) begin
               wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
            end
            if (deq_vec[i]) begin
               rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            end
            if (wr_vec[i] && !deq_vec[i]) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end else if (!wr_vec[i] && deq_vec[i]) begin
               cnt_q[i] <= cnt_q[i] - 1'b1;
            end
         end
      end
   end

   // Arbiter state, output flit, credit pulses and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked_q     <= 1'b0;
         owner_q      <= '0;
         rr_q         <= '0;
         flit_out     <= '0;
         cntrl_out    <= '0;
         overflow_err <= 1'b0;
      end else begin
         locked_q     <= locked_d;
         owner_q      <= owner_d;
         rr_q         <= rr_d;
         flit_out     <= flit_out_d;
         cntrl_out    <= deq_vec;
         overflow_err <= overflow_err | ovf_set;
      end
   end

   for (genvar g = 0; g < global_links_num; g++) begin : gen_occ
      assign occupancy[5*g +: 5] = 5'(cnt_q[g]);
   end

endmodule
